// File: rtl/ro_puf_challenge_if.sv
// rtl/ro_puf_challenge_if.sv - request/response bundle between a controller and the RO-PUF evaluator
interface ro_puf_challenge_if #(
    parameter int NUM_RO    = 8,
    parameter int RESP_BITS = 4
);
    localparam int SEL_W = $clog2(NUM_RO);
    localparam int CH_W  = RESP_BITS * 2 * SEL_W;

    logic                 start;
    logic                 abort;
    logic [CH_W-1:0]      challenge;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] unstable;

    modport master (
        output start, abort, challenge,
        input  busy, done, response, unstable
    );

    modport slave (
        input  start, abort, challenge,
        output busy, done, response, unstable
    );
endinterface

// File: rtl/ro_puf_challenge.sv
// rtl/ro_puf_challenge.sv - ring-oscillator PUF evaluator: one pairwise edge-count race per response bit
module ro_puf_challenge #(
    parameter int NUM_RO    = 8,
    parameter int RESP_BITS = 4,
    parameter int WIN_CYC   = 64,
    parameter int CNT_W     = 16,
    parameter int MARGIN    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_in,
    ro_puf_challenge_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_RO);
    localparam int CH_W  = RESP_BITS * 2 * SEL_W;
    localparam int K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int WIN_W = $clog2(WIN_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   MARGIN_V = (CNT_W+1)'(MARGIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_RO-1:0]    sync1_q, sync1_d;
    logic [NUM_RO-1:0]    sync2_q, sync2_d;
    logic [NUM_RO-1:0]    prev_q, prev_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic                 invalid_q, invalid_d;
    logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
    logic                 sat_q, sat_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [RESP_BITS-1:0] shadow_resp_q, shadow_resp_d;
    logic [RESP_BITS-1:0] shadow_unst_q, shadow_unst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic [RESP_BITS-1:0] unstable_q, unstable_d;

    logic [NUM_RO-1:0] rise;
    logic [SEL_W-1:0]  idx_a, idx_b;
    logic              pair_bad;
    logic              inc_a, inc_b;
    logic [CNT_W:0]    diff;
    logic              close;

    // Edge detect runs on the synchronized copy, so one count per clean 0->1 of each oscillator.
    assign rise  = sync2_q & ~prev_q;
    assign inc_a = rise[sel_a_q];
    assign inc_b = rise[sel_b_q];

    always_comb begin
        idx_a    = ch_q[int'(k_q) * 2 * SEL_W +: SEL_W];
        idx_b    = ch_q[int'(k_q) * 2 * SEL_W + SEL_W +: SEL_W];
        pair_bad = (idx_a == idx_b) || (int'(idx_a) >= NUM_RO) || (int'(idx_b) >= NUM_RO);
    end

    // Magnitude taken one bit wider than the counters so the subtraction can never wrap.
    always_comb begin
        if (cnt_a_q > cnt_b_q) begin
            diff = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
        end else begin
            diff = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
        end
        close = (diff <= MARGIN_V);
    end

    always_comb begin
        sync1_d       = ro_in;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        state_d       = state_q;
        k_d           = k_q;
        ch_d          = ch_q;
        sel_a_d       = sel_a_q;
        sel_b_d       = sel_b_q;
        invalid_d     = invalid_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        sat_d         = sat_q;
        win_d         = win_q;
        shadow_resp_d = shadow_resp_q;
        shadow_unst_d = shadow_unst_q;
        response_d    = response_q;
        unstable_d    = unstable_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    ch_d    = bus.challenge;
                    k_d     = '0;
                end
            end
            S_LOAD: begin
                cnt_a_d   = '0;
                cnt_b_d   = '0;
                sat_d     = 1'b0;
                win_d     = '0;
                sel_a_d   = idx_a;
                sel_b_d   = idx_b;
                invalid_d = pair_bad;
                state_d   = pair_bad ? S_COMPARE : S_MEASURE;
            end
            S_MEASURE: begin
                win_d = win_q + 1'b1;
                if (inc_a && (cnt_a_q != CNT_MAX)) begin
                    cnt_a_d = cnt_a_q + 1'b1;
                end
                if (inc_b && (cnt_b_q != CNT_MAX)) begin
                    cnt_b_d = cnt_b_q + 1'b1;
                end
                sat_d = sat_q | (cnt_a_d == CNT_MAX) | (cnt_b_d == CNT_MAX);
                if (int'(win_q) == WIN_CYC - 1) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                shadow_resp_d[k_q] = (cnt_a_q > cnt_b_q);
                shadow_unst_d[k_q] = close | sat_q | invalid_q;
                if (int'(k_q) == RESP_BITS - 1) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                response_d = shadow_resp_q;
                unstable_d = shadow_unst_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel outranks every other transition; published outputs are left alone.
        if (bus.abort && ((state_q == S_LOAD) || (state_q == S_MEASURE) || (state_q == S_COMPARE))) begin
            state_d = S_IDLE;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_MEASURE) || (state_d == S_COMPARE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            k_q           <= '0;
            ch_q          <= '0;
            sel_a_q       <= '0;
            sel_b_q       <= '0;
            invalid_q     <= 1'b0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            sat_q         <= 1'b0;
            win_q         <= '0;
            shadow_resp_q <= '0;
            shadow_unst_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            response_q    <= '0;
            unstable_q    <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            k_q           <= k_d;
            ch_q          <= ch_d;
            sel_a_q       <= sel_a_d;
            sel_b_q       <= sel_b_d;
            invalid_q     <= invalid_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            sat_q         <= sat_d;
            win_q         <= win_d;
            shadow_resp_q <= shadow_resp_d;
            shadow_unst_q <= shadow_unst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            response_q    <= response_d;
            unstable_q    <= unstable_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = response_q;
    assign bus.unstable = unstable_q;
endmodule

// File: tb/tb_ro_puf_challenge.sv
// tb/tb_ro_puf_challenge.sv - bench for ro_puf_challenge: 16-bit and saturating 4-bit instances in lockstep
module tb_ro_puf_challenge;
    localparam int NUM_RO = 8;
    localparam int WIN    = 64;
    localparam int CH_W   = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CH_W-1:0]   challenge;
    logic [NUM_RO-1:0] ro_in;
    int                per [NUM_RO];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [3:0]        prior_resp_a, prior_unst_a, prior_resp_b, prior_unst_b;

    ro_puf_challenge_if #(.NUM_RO(NUM_RO), .RESP_BITS(4)) bus_a ();
    ro_puf_challenge_if #(.NUM_RO(NUM_RO), .RESP_BITS(4)) bus_b ();

    assign bus_a.start     = start;
    assign bus_a.abort     = abort;
    assign bus_a.challenge = challenge;
    assign bus_b.start     = start;
    assign bus_b.abort     = abort;
    assign bus_b.challenge = challenge;

    ro_puf_challenge #(.NUM_RO(NUM_RO), .RESP_BITS(4), .WIN_CYC(WIN), .CNT_W(16), .MARGIN(2)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .bus(bus_a)
    );
    ro_puf_challenge #(.NUM_RO(NUM_RO), .RESP_BITS(4), .WIN_CYC(WIN), .CNT_W(4), .MARGIN(2)) dut_sat (
        .clk(clk), .rst(rst), .ro_in(ro_in), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    // Square waves locked to a free-running cycle count; period 0 means a static-low input.
    always_comb begin
        for (int i = 0; i < NUM_RO; i++) begin
            if (per[i] == 0) ro_in[i] = 1'b0;
            else             ro_in[i] = ((cyc % per[i]) < (per[i] / 2));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Any window of WIN cycles holds exactly WIN/period rising edges when period divides WIN.
    function automatic int edges(input int i);
        if (i >= NUM_RO || per[i] == 0) return 0;
        return WIN / per[i];
    endfunction

    function automatic void model(input logic [CH_W-1:0] ch, input int cnt_w,
                                  output logic [3:0] resp, output logic [3:0] unst, output int lat);
        int mx, a, b, ea, eb, ca, cb, d;
        mx   = (1 << cnt_w) - 1;
        lat  = 1;
        resp = '0;
        unst = '0;
        for (int k = 0; k < 4; k++) begin
            a = int'(ch[6*k +: 3]);
            b = int'(ch[6*k+3 +: 3]);
            if (a == b || a >= NUM_RO || b >= NUM_RO) begin
                lat += 2;
                unst[k] = 1'b1;
            end else begin
                lat += WIN + 2;
                ea = edges(a);
                eb = edges(b);
                ca = (ea > mx) ? mx : ea;
                cb = (eb > mx) ? mx : eb;
                d  = (ca > cb) ? ca - cb : cb - ca;
                resp[k] = (ca > cb);
                unst[k] = (d <= 2) || (ea >= mx) || (eb >= mx);
            end
        end
    endfunction

    function automatic logic [CH_W-1:0] mk_ch(input int a0, b0, a1, b1, a2, b2, a3, b3);
        logic [2:0] v [8];
        v = '{3'(a0), 3'(b0), 3'(a1), 3'(b1), 3'(a2), 3'(b2), 3'(a3), 3'(b3)};
        return {v[7], v[6], v[5], v[4], v[3], v[2], v[1], v[0]};
    endfunction

    function automatic logic [CH_W-1:0] rand_ch(input bit allow_bad);
        logic [CH_W-1:0] ch;
        int a, b;
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, 7);
            if (allow_bad && $urandom_range(0, 3) == 0) b = a;
            else b = (a + $urandom_range(1, 7)) % 8;
            ch[6*k +: 3]   = 3'(a);
            ch[6*k+3 +: 3] = 3'(b);
        end
        return ch;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input string tag, input logic [CH_W-1:0] ch, input int repulse_at,
                            output int lat_seen);
        logic [3:0] er_a, eu_a, er_b, eu_b;
        int el, el_b, m;
        bit found;
        model(ch, 16, er_a, eu_a, el);
        model(ch, 4, er_b, eu_b, el_b);
        challenge = ch;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m = 0;
        found = 0;
        while (!found && m < 2000) begin
            @(posedge clk);
            m++;
            #1;
            if (m == 1) check({tag, "_busy"}, bus_a.busy, 1);
            if (m == repulse_at) start = 1'b1;
            if (m == repulse_at + 1) start = 1'b0;
            if (bus_a.done) found = 1;
        end
        check({tag, "_lat"}, m, el);
        check({tag, "_done_b"}, bus_b.done, 1);
        check({tag, "_resp_a"}, bus_a.response, er_a);
        check({tag, "_unst_a"}, bus_a.unstable, eu_a);
        check({tag, "_resp_b"}, bus_b.response, er_b);
        check({tag, "_unst_b"}, bus_b.unstable, eu_b);
        prior_resp_a = er_a;
        prior_unst_a = eu_a;
        prior_resp_b = er_b;
        prior_unst_b = eu_b;
        lat_seen = m;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, bus_a.done, 0);
        check({tag, "_idle_busy"}, bus_a.busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {bus_a.busy, bus_b.busy}, 0);
        check({tag, "_done"}, {bus_a.done, bus_b.done}, 0);
        check({tag, "_resp"}, {bus_a.response, bus_b.response}, 0);
        check({tag, "_unst"}, {bus_a.unstable, bus_b.unstable}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic [CH_W-1:0] ch037, ch;
        int lat, cnt_done;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        challenge = '0;
        per       = '{4, 8, 8, 4, 0, 0, 0, 0};
        settle(3);
        check_zero("reset");
        rst = 1'b0;
        settle(8);

        ch037 = mk_ch(0, 1, 2, 3, 4, 5, 6, 7);
        run_eval("ordered", ch037, 0, lat);
        check("ordered_lat_abs", lat, 4 * 66 + 1);
        check("ordered_resp_abs", bus_a.response, 4'b0001);
        check("ordered_unst_abs", bus_a.unstable, 4'b1100);

        per = '{0, 8, 8, 0, 0, 0, 0, 0};
        settle(8);
        run_eval("tie", mk_ch(1, 2, 1, 2, 1, 2, 1, 2), 0, lat);
        check("tie_bit0", {bus_a.response[0], bus_a.unstable[0]}, 2'b01);

        run_eval("invalid", mk_ch(3, 3, 3, 3, 3, 3, 3, 3), 0, lat);
        check("invalid_lat_abs", lat, 4 * 2 + 1);
        check("invalid_unst_abs", bus_a.unstable, 4'b1111);

        per = '{2, 0, 0, 0, 0, 0, 0, 0};
        settle(8);
        run_eval("sat", mk_ch(0, 1, 0, 1, 0, 1, 0, 1), 0, lat);
        check("sat_bit0", {bus_b.response[0], bus_b.unstable[0]}, 2'b11);

        abort = 1'b1;
        settle(1);
        abort = 1'b0;
        check("abort_idle_busy", bus_a.busy, 0);
        check("abort_idle_resp", bus_a.response, prior_resp_a);

        for (int it = 0; it < 8; it++) begin
            int opts [7];
            opts = '{0, 2, 4, 8, 16, 32, 64};
            for (int i = 0; i < NUM_RO; i++) per[i] = opts[$urandom_range(0, 6)];
            settle(8);
            run_eval($sformatf("rand%0d", it), rand_ch(1), 0, lat);
        end

        ch = rand_ch(0);
        challenge = ch;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        settle(140);
        abort = 1'b1;
        settle(1);
        abort = 1'b0;
        check("abort_busy", {bus_a.busy, bus_b.busy}, 0);
        cnt_done = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus_a.done || bus_b.done) cnt_done++;
            settle(1);
        end
        check("abort_no_done", cnt_done, 0);
        check("abort_resp_a", {bus_a.response, bus_a.unstable}, {prior_resp_a, prior_unst_a});
        check("abort_resp_b", {bus_b.response, bus_b.unstable}, {prior_resp_b, prior_unst_b});
        run_eval("after_abort", ch, 0, lat);

        per = '{4, 8, 8, 4, 0, 0, 0, 0};
        settle(8);
        challenge = ch037;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        settle(30);
        #3 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        settle(8);
        run_eval("post_rst", ch037, 20, lat);
        check("post_rst_lat_abs", lat, 4 * 66 + 1);
        check("post_rst_resp_abs", {bus_a.response, bus_a.unstable}, {4'b0001, 4'b1100});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
